// File: rtl/rgb_pwm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pwm_sequencer
// Purpose  : Three-channel RGB PWM engine with hue-wheel, breathe, static and
//            off modes. Duties are double-buffered into shadow registers at
//            period end so the pin waveforms never glitch mid-period.
// Revision : 1.0 - initial release
// ============================================================================
module rgb_pwm_sequencer #(
  parameter int PWM_INTERVAL     = 1200,
  parameter int DUTY_STEP        = 12,
  parameter int PERIODS_PER_STEP = 100,
  parameter bit ACTIVE_LOW       = 1'b1,
  localparam int W               = $clog2(PWM_INTERVAL + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     mode,
  input  logic           reverse,
  input  logic [2:0]     chan_mask,
  input  logic [3*W-1:0] static_duty,
  output logic           RGB_R,
  output logic           RGB_G,
  output logic           RGB_B,
  output logic           period_start,
  output logic [2:0]     hue_segment
);

  localparam int            SW          = (PERIODS_PER_STEP > 1) ? $clog2(PERIODS_PER_STEP) : 1;
  localparam logic [W-1:0]  c_MAX       = W'(PWM_INTERVAL);
  localparam logic [W-1:0]  c_STEP      = W'(DUTY_STEP);
  localparam logic [W-1:0]  c_CNT_LAST  = W'(PWM_INTERVAL - 1);
  localparam logic [SW-1:0] c_STEP_LAST = SW'(PERIODS_PER_STEP - 1);

  localparam logic [1:0] c_MODE_HUE     = 2'b00;
  localparam logic [1:0] c_MODE_BREATHE = 2'b01;
  localparam logic [1:0] c_MODE_STATIC  = 2'b10;

  typedef enum logic [2:0] {
    SEG0 = 3'd0,
    SEG1 = 3'd1,
    SEG2 = 3'd2,
    SEG3 = 3'd3,
    SEG4 = 3'd4,
    SEG5 = 3'd5
  } seg_t;

  logic [W-1:0]          r_pwm_cnt;
  logic [SW-1:0]         r_step_cnt;
  logic                  w_period_end;
  logic                  w_step;

  seg_t                  r_seg;
  seg_t                  w_seg_nxt;
  logic [W-1:0]          r_ramp;
  logic [W-1:0]          w_ramp_nxt;
  logic [W-1:0]          w_ramp_up;

  logic [W-1:0]          r_level;
  logic [W-1:0]          w_level_nxt;
  logic                  r_dir_dn;
  logic                  w_dir_dn_nxt;

  // Index 0 = R, 1 = G, 2 = B throughout.
  logic [2:0][W-1:0]     w_hue;
  logic [2:0][W-1:0]     w_work;
  logic [2:0][W-1:0]     r_shadow;
  logic [2:0]            w_on;
  logic [2:0]            r_pins;
  logic                  r_period_start;

  assign w_period_end = (r_pwm_cnt == c_CNT_LAST);
  assign w_step       = w_period_end && (r_step_cnt == c_STEP_LAST);
  assign w_ramp_up    = r_ramp + c_STEP;

  // PWM period counter and ramp-step prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pwm_cnt  <= '0;
      r_step_cnt <= '0;
    end else begin
      r_pwm_cnt <= w_period_end ? '0 : r_pwm_cnt + W'(1);
      if (w_period_end) begin
        r_step_cnt <= (r_step_cnt == c_STEP_LAST) ? '0 : r_step_cnt + SW'(1);
      end
    end
  end

  // Hue FSM state register (segment plus intra-segment ramp).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_seg  <= SEG0;
      r_ramp <= '0;
    end else begin
      r_seg  <= w_seg_nxt;
      r_ramp <= w_ramp_nxt;
    end
  end

  // Hue FSM next state: only steps in hue mode, otherwise holds position.
  always_comb begin
    w_seg_nxt  = r_seg;
    w_ramp_nxt = r_ramp;
    if (w_step && (mode == c_MODE_HUE)) begin
      if (!reverse) begin
        if (w_ramp_up == c_MAX) begin
          w_ramp_nxt = '0;
          w_seg_nxt  = (r_seg == SEG5) ? SEG0 : seg_t'(r_seg + 3'd1);
        end else begin
          w_ramp_nxt = w_ramp_up;
        end
      end else begin
        if (r_ramp == '0) begin
          w_ramp_nxt = c_MAX - c_STEP;
          w_seg_nxt  = (r_seg == SEG0) ? SEG5 : seg_t'(r_seg - 3'd1);
        end else begin
          w_ramp_nxt = r_ramp - c_STEP;
        end
      end
    end
  end

  // Hue duties: one channel full, one ramping, one dark per segment.
  always_comb begin
    w_hue = '0;
    case (r_seg)
      SEG0: begin w_hue[0] = c_MAX;          w_hue[1] = r_ramp;          end
      SEG1: begin w_hue[0] = c_MAX - r_ramp; w_hue[1] = c_MAX;           end
      SEG2: begin w_hue[1] = c_MAX;          w_hue[2] = r_ramp;          end
      SEG3: begin w_hue[1] = c_MAX - r_ramp; w_hue[2] = c_MAX;           end
      SEG4: begin w_hue[2] = c_MAX;          w_hue[0] = r_ramp;          end
      SEG5: begin w_hue[2] = c_MAX - r_ramp; w_hue[0] = c_MAX;           end
      default: w_hue = '0;
    endcase
  end

  // Breathe level and direction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level  <= '0;
      r_dir_dn <= 1'b0;
    end else begin
      r_level  <= w_level_nxt;
      r_dir_dn <= w_dir_dn_nxt;
    end
  end

  // Breathe triangle: direction flips on landing at an endpoint, so each
  // endpoint is shown for exactly one step and the level never overshoots.
  always_comb begin
    w_level_nxt  = r_level;
    w_dir_dn_nxt = r_dir_dn;
    if (w_step && (mode == c_MODE_BREATHE)) begin
      if (!r_dir_dn) begin
        w_level_nxt = r_level + c_STEP;
        if ((r_level + c_STEP) == c_MAX) begin
          w_dir_dn_nxt = 1'b1;
        end
      end else begin
        w_level_nxt = r_level - c_STEP;
        if ((r_level - c_STEP) == '0) begin
          w_dir_dn_nxt = 1'b0;
        end
      end
    end
  end

  // Per-channel working duty (mode select, static clamp, mask) and compare.
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [W-1:0] w_sd;
    logic [W-1:0] w_clamp;
    logic [W-1:0] w_sel;
    assign w_sd       = static_duty[gi*W +: W];
    assign w_clamp    = (w_sd > c_MAX) ? c_MAX : w_sd;
    assign w_sel      = (mode == c_MODE_HUE)     ? w_hue[gi] :
                        (mode == c_MODE_BREATHE) ? r_level   :
                        (mode == c_MODE_STATIC)  ? w_clamp   : '0;
    assign w_work[gi] = chan_mask[gi] ? w_sel : '0;
    assign w_on[gi]   = (r_pwm_cnt < r_shadow[gi]);
  end

  // Shadow duty load at period end plus registered pin and period pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow       <= '0;
      r_pins         <= ACTIVE_LOW ? 3'b111 : 3'b000;
      r_period_start <= 1'b0;
    end else begin
      if (w_period_end) begin
        r_shadow <= w_work;
      end
      r_pins         <= ACTIVE_LOW ? ~w_on : w_on;
      r_period_start <= (r_pwm_cnt == '0);
    end
  end

  assign RGB_R        = r_pins[0];
  assign RGB_G        = r_pins[1];
  assign RGB_B        = r_pins[2];
  assign period_start = r_period_start;
  assign hue_segment  = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_pwm_sequencer
// Purpose  : Self-checking bench for rgb_pwm_sequencer (12-clock period,
//            step 3, two periods per step, active-low pins).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rgb_pwm_sequencer;

  localparam int N   = 12;
  localparam int STP = 3;
  localparam int W   = 4;

  logic           clk;
  logic           reset;
  logic [1:0]     mode;
  logic           reverse;
  logic [2:0]     chan_mask;
  logic [3*W-1:0] static_duty;
  logic           RGB_R, RGB_G, RGB_B, period_start;
  logic [2:0]     hue_segment;

  int total;
  int bad;
  logic [3:0] sb[$];

  rgb_pwm_sequencer #(
    .PWM_INTERVAL(N), .DUTY_STEP(STP), .PERIODS_PER_STEP(2), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .reverse(reverse),
    .chan_mask(chan_mask), .static_duty(static_duty),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B),
    .period_start(period_start), .hue_segment(hue_segment)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hue position after n steps from reset.
  function automatic void hue_model(input int n, input bit rev, output int seg, output int ramp);
    seg = 0; ramp = 0;
    for (int s = 0; s < n; s++) begin
      if (!rev) begin
        ramp += STP;
        if (ramp == N) begin ramp = 0; seg = (seg + 1) % 6; end
      end else begin
        if (ramp == 0) begin ramp = N - STP; seg = (seg + 5) % 6; end
        else ramp -= STP;
      end
    end
  endfunction

  function automatic void hue_duty(input int seg, input int ramp, output int r, output int g, output int b);
    r = 0; g = 0; b = 0;
    case (seg)
      0: begin r = N;        g = ramp;     end
      1: begin r = N - ramp; g = N;        end
      2: begin g = N;        b = ramp;     end
      3: begin g = N - ramp; b = N;        end
      4: begin b = N;        r = ramp;     end
      default: begin b = N - ramp; r = N;  end
    endcase
  endfunction

  function automatic int breathe_model(input int n);
    int lvl; bit up;
    lvl = 0; up = 1'b1;
    for (int s = 0; s < n; s++) begin
      if (up) begin lvl += STP; if (lvl == N) up = 1'b0; end
      else    begin lvl -= STP; if (lvl == 0) up = 1'b1; end
    end
    return lvl;
  endfunction

  // Assert reset, release on a falling edge, return at the first output cycle.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Push one period of expected {period_start,B,G,R}, then pop and compare
  // cycle by cycle. Optionally change static_duty after cycle chg_k.
  task automatic check_period(input int dr, input int dg, input int db, input string tag,
                              input int chg_k, input logic [3*W-1:0] chg_val);
    logic [3:0] exp, obs;
    for (int k = 0; k < N; k++) begin
      sb.push_back({(k == 0), !(k < db), !(k < dg), !(k < dr)});
    end
    for (int k = 0; k < N; k++) begin
      exp = sb.pop_front();
      obs = {period_start, RGB_B, RGB_G, RGB_R};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s k=%0d {ps,B,G,R} got=%b want=%b", tag, k, obs, exp);
      end
      if (k == chg_k) static_duty = chg_val;
      @(negedge clk);
    end
  endtask

  task automatic run_hue(input bit rev, input int nper, input string tag);
    int seg, ramp, r, g, b;
    for (int p = 0; p < nper; p++) begin
      hue_model(p / 2, rev, seg, ramp);
      total++;
      if (hue_segment !== 3'(seg)) begin
        bad++;
        $display("FAIL %s_seg p=%0d got=%0d want=%0d", tag, p, hue_segment, seg);
      end
      if (p == 0) begin
        r = 0; g = 0; b = 0;
      end else begin
        hue_model((p - 1) / 2, rev, seg, ramp);
        hue_duty(seg, ramp, r, g, b);
      end
      check_period(r, g, b, tag, -1, static_duty);
    end
  endtask

  task automatic test_reset();
    mode = 2'b11; reverse = 1'b0; chan_mask = 3'b111; static_duty = '0;
    reset = 1'b1;
    #3;
    total++;
    if ({period_start, RGB_B, RGB_G, RGB_R, hue_segment} !== 7'b0111_000) begin
      bad++;
      $display("FAIL reset_state got=%b want=%b",
               {period_start, RGB_B, RGB_G, RGB_R, hue_segment}, 7'b0111_000);
    end
    do_reset();
    check_period(0, 0, 0, "reset_p0", -1, static_duty);
    check_period(0, 0, 0, "off_p1", -1, static_duty);
  endtask

  task automatic test_static();
    mode = 2'b10; chan_mask = 3'b111;
    static_duty = {4'd12, 4'd0, 4'd6};
    do_reset();
    check_period(0, 0, 0, "static_p0", -1, static_duty);
    check_period(6, 0, 12, "static_a", -1, static_duty);
    // Raise R beyond max at a period start; takes effect one period later.
    check_period(6, 0, 12, "static_b", 0, {4'd12, 4'd0, 4'd15});
    check_period(12, 0, 12, "static_clamp", -1, static_duty);
  endtask

  task automatic test_mid_change();
    check_period(12, 0, 12, "mid_pre", 0, {4'd12, 4'd0, 4'd0});
    check_period(0, 0, 12, "mid_zero", 5, {4'd12, 4'd0, 4'd12});
    check_period(12, 0, 12, "mid_new", -1, static_duty);
  endtask

  task automatic test_hue_fwd();
    mode = 2'b00; reverse = 1'b0; chan_mask = 3'b111;
    do_reset();
    run_hue(1'b0, 52, "hue_fwd");
  endtask

  task automatic test_hue_rev();
    mode = 2'b00; reverse = 1'b1; chan_mask = 3'b111;
    do_reset();
    run_hue(1'b1, 10, "hue_rev");
  endtask

  task automatic test_breathe();
    int lvl;
    mode = 2'b01; reverse = 1'b0; chan_mask = 3'b101;
    do_reset();
    for (int p = 0; p < 22; p++) begin
      lvl = (p == 0) ? 0 : breathe_model((p - 1) / 2);
      check_period(lvl, 0, lvl, "breathe", -1, static_duty);
    end
  endtask

  task automatic test_async_reset();
    mode = 2'b00; reverse = 1'b0; chan_mask = 3'b111;
    do_reset();
    run_hue(1'b0, 18, "pre_async");
    repeat (3) @(negedge clk);
    total++;
    if ({RGB_G, hue_segment} !== 4'b0_010) begin
      bad++;
      $display("FAIL async_pre {G,seg} got=%b want=%b", {RGB_G, hue_segment}, 4'b0_010);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({period_start, RGB_B, RGB_G, RGB_R, hue_segment} !== 7'b0111_000) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b",
               {period_start, RGB_B, RGB_G, RGB_R, hue_segment}, 7'b0111_000);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({period_start, hue_segment} !== 4'b1_000) begin
      bad++;
      $display("FAIL async_release {ps,seg} got=%b want=%b", {period_start, hue_segment}, 4'b1_000);
    end
    check_period(0, 0, 0, "async_p0", -1, static_duty);
    check_period(12, 0, 0, "async_p1", -1, static_duty);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_static();
    test_mid_change();
    test_hue_fwd();
    test_hue_rev();
    test_breathe();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
